// File: rtl/tpu_slot_sched.sv
// ----------------------------------------------------------------------------
// tpu_slot_sched
//
// Purpose:
//   Frame-by-frame slot scheduler for the tpu timing block. A small
//   programmable table holds {repeat, rx_en, tx_en, rx_slot, tx_slot} entries.
//   Once started, the scheduler walks entries 0..LAST_IDX and applies each one
//   atomically on FRAME_TICK. An entry stays on the outputs for repeat+1
//   frames before the next entry is applied.
//
// Optional feature:
//   TPU_SCHED_CONFLICT_CHK_EN - when defined, an applied entry with both
//   enables set and tx_slot == rx_slot has its RX enable suppressed, and
//   CONFLICT pulses for one cycle. When undefined, entries are applied
//   verbatim and CONFLICT is tied low.
//
// Ports:
//   SYS_CLK     in   system clock (rising edge)
//   RSTSCH      in   synchronous active-high reset (table is not cleared)
//   WR_EN       in   table write strobe
//   WR_ADDR     in   table write address
//   WR_DATA     in   entry {repeat, rx_en, tx_en, rx_slot, tx_slot}
//   LAST_IDX    in   index of the last active entry, latched on START
//   START       in   begin schedule (pulse, honoured only in IDLE)
//   STOP        in   end schedule (pulse, wins over START)
//   FRAME_TICK  in   frame-start pulse from the tpu
//   TX_SLOT     out  applied TX slot
//   RX_SLOT     out  applied RX slot
//   TXSLOT_EN   out  applied TX enable
//   RXSLOT_EN   out  applied RX enable
//   CUR_IDX     out  index of the entry currently applied
//   BUSY        out  high in any state other than IDLE
//   WRAP_IRQ    out  one-cycle pulse when the index wraps LAST_IDX -> 0
//   CONFLICT    out  one-cycle pulse when an applied entry had an RX/TX clash
// ----------------------------------------------------------------------------
module tpu_slot_sched #(
  parameter  int DEPTH   = 8,
  parameter  int SLOT_W  = 8,
  parameter  int RPT_W   = 4,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int ENTRY_W = 2 * SLOT_W + 2 + RPT_W
) (
  input  logic               SYS_CLK,
  input  logic               RSTSCH,
  input  logic               WR_EN,
  input  logic [IDX_W-1:0]   WR_ADDR,
  input  logic [ENTRY_W-1:0] WR_DATA,
  input  logic [IDX_W-1:0]   LAST_IDX,
  input  logic               START,
  input  logic               STOP,
  input  logic               FRAME_TICK,
  output logic [SLOT_W-1:0]  TX_SLOT,
  output logic [SLOT_W-1:0]  RX_SLOT,
  output logic               TXSLOT_EN,
  output logic               RXSLOT_EN,
  output logic [IDX_W-1:0]   CUR_IDX,
  output logic               BUSY,
  output logic               WRAP_IRQ,
  output logic               CONFLICT
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARM      = 2'd1,
    S_RUN      = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  state_t              state_q;
  logic [ENTRY_W-1:0]  table_q [DEPTH];
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    idx_q;
  logic [RPT_W-1:0]    rpt_q;
  logic [SLOT_W-1:0]   tx_slot_q;
  logic [SLOT_W-1:0]   rx_slot_q;
  logic                tx_en_q;
  logic                rx_en_q;
  logic                wrap_q;
  logic                conflict_q;

  // Entry selection for the next apply.
  logic                wrap_d;
  logic [IDX_W-1:0]    apply_idx_d;
  logic [ENTRY_W-1:0]  entry_d;
  logic [SLOT_W-1:0]   ent_tx_d;
  logic [SLOT_W-1:0]   ent_rx_d;
  logic                ent_tx_en_d;
  logic                ent_rx_en_d;
  logic [RPT_W-1:0]    ent_rpt_d;
  logic                ent_conflict_d;
  logic                ent_rx_en_eff_d;

  // Table storage. Not reset so the schedule survives RSTSCH. The apply path
  // reads the array in the same cycle as a possible write, so a colliding
  // apply naturally sees the old contents and the new value from next cycle.
  always_ff @(posedge SYS_CLK) begin
    if (WR_EN) begin
      table_q[WR_ADDR] <= WR_DATA;
    end
  end

  always_comb begin
    wrap_d      = (idx_q == last_q);
    apply_idx_d = '0;
    // In ARM the first apply is always entry 0; in RUN it is the successor.
    if (state_q == S_RUN && !wrap_d) begin
      apply_idx_d = idx_q + 1'b1;
    end
  end

  assign entry_d     = table_q[apply_idx_d];
  assign ent_tx_d    = entry_d[SLOT_W-1:0];
  assign ent_rx_d    = entry_d[2*SLOT_W-1:SLOT_W];
  assign ent_tx_en_d = entry_d[2*SLOT_W];
  assign ent_rx_en_d = entry_d[2*SLOT_W+1];
  assign ent_rpt_d   = entry_d[ENTRY_W-1 -: RPT_W];

`ifdef TPU_SCHED_CONFLICT_CHK_EN
  // TX and RX on the same slot cannot both be served; TX takes precedence.
  assign ent_conflict_d = ent_tx_en_d & ent_rx_en_d & (ent_tx_d == ent_rx_d);
`else
  assign ent_conflict_d = 1'b0;
`endif

  assign ent_rx_en_eff_d = ent_rx_en_d & ~ent_conflict_d;

  // Scheduler FSM with registered outputs.
  always_ff @(posedge SYS_CLK) begin
    if (RSTSCH) begin
      state_q    <= S_IDLE;
      last_q     <= '0;
      idx_q      <= '0;
      rpt_q      <= '0;
      tx_slot_q  <= '0;
      rx_slot_q  <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // STOP in the same cycle suppresses START.
          if (START && !STOP) begin
            last_q  <= LAST_IDX;
            idx_q   <= '0;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          if (STOP) begin
            state_q <= S_IDLE;
          end else if (FRAME_TICK) begin
            tx_slot_q  <= ent_tx_d;
            rx_slot_q  <= ent_rx_d;
            tx_en_q    <= ent_tx_en_d;
            rx_en_q    <= ent_rx_en_eff_d;
            conflict_q <= ent_conflict_d;
            idx_q      <= apply_idx_d;
            rpt_q      <= ent_rpt_d;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          // STOP takes priority over a coincident tick: outputs are held
          // and the disable happens on the following tick.
          if (STOP) begin
            state_q <= S_STOPPING;
          end else if (FRAME_TICK) begin
            if (rpt_q != '0) begin
              rpt_q <= rpt_q - 1'b1;
            end else begin
              tx_slot_q  <= ent_tx_d;
              rx_slot_q  <= ent_rx_d;
              tx_en_q    <= ent_tx_en_d;
              rx_en_q    <= ent_rx_en_eff_d;
              conflict_q <= ent_conflict_d;
              idx_q      <= apply_idx_d;
              rpt_q      <= ent_rpt_d;
              wrap_q     <= wrap_d;
            end
          end
        end
        S_STOPPING: begin
          if (FRAME_TICK) begin
            tx_en_q <= 1'b0;
            rx_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TX_SLOT   = tx_slot_q;
  assign RX_SLOT   = rx_slot_q;
  assign TXSLOT_EN = tx_en_q;
  assign RXSLOT_EN = rx_en_q;
  assign CUR_IDX   = idx_q;
  assign BUSY      = (state_q != S_IDLE);
  assign WRAP_IRQ  = wrap_q;
  assign CONFLICT  = conflict_q;

endmodule

// File: doc/tpu_slot_sched.md
# tpu_slot_sched

Frame-by-frame slot scheduler that sits in front of the `tpu` timing block and drives its slot configuration inputs (`TX_SLOT`, `RX_SLOT`, `TXSLOT_EN`, `RXSLOT_EN`). The block holds a small programmable schedule table, walks it one entry per frame group, and applies each entry atomically on the TPU's frame-start tick. This lets the TX/RX slot pattern change across frames without per-frame processor intervention.

## Interface
Parameters:
- `DEPTH`, 8: schedule table entries (power of two, 2..16).
- `SLOT_W`, 8: slot number width; matches the TPU `TX_SLOT`/`RX_SLOT` width.
- `RPT_W`, 4: per-entry repeat count width.

Ports:
- `SYS_CLK` in 1: system clock; all logic on the rising edge.
- `RSTSCH` in 1: synchronous, active-high reset.
- `WR_EN` in 1: table write strobe.
- `WR_ADDR` in log2(DEPTH): table write address.
- `WR_DATA` in 2*SLOT_W+2+RPT_W: entry, packed as {repeat, rx_en, tx_en, rx_slot, tx_slot}, with tx_slot in the LSBs.
- `LAST_IDX` in log2(DEPTH): index of the last active entry; sampled on `START`.
- `START` in 1: begin schedule (pulse).
- `STOP` in 1: end schedule (pulse).
- `FRAME_TICK` in 1: one-cycle frame-start pulse from the TPU.
- `TX_SLOT` out SLOT_W; `RX_SLOT` out SLOT_W; `TXSLOT_EN` out 1; `RXSLOT_EN` out 1: TPU configuration.
- `CUR_IDX` out log2(DEPTH): index of the entry currently applied.
- `BUSY` out 1: high in any state other than IDLE.
- `WRAP_IRQ` out 1: one-cycle pulse when the index wraps from `LAST_IDX` to 0.
- `CONFLICT` out 1: one-cycle pulse when an applied entry has an RX/TX collision (see Configuration).

## Operation
- States:
  - IDLE: TPU outputs held at last values, enables 0.
  - ARM: wait for the first tick.
  - RUN: schedule active.
  - STOPPING: wait for a tick to disable.
- IDLE + `START`:
  - latch `LAST_IDX`, set `CUR_IDX`=0, go to ARM.
  - `START` in any other state is ignored.
- ARM + `FRAME_TICK`: apply entry 0, load repeat counter from entry.repeat, go to RUN.
- RUN + `FRAME_TICK`:
  - If the repeat counter is nonzero, decrement it and hold the outputs.
  - Otherwise advance `CUR_IDX`, apply that entry and reload the counter.
  - Wrap: `CUR_IDX` goes from latched `LAST_IDX` to 0, and `WRAP_IRQ` pulses.
  - An entry therefore occupies repeat+1 frames.
  - `LAST_IDX`=0 means entry 0 repeats forever, with `WRAP_IRQ` on every reload.
- `STOP`:
  - ARM: go to IDLE immediately.
  - RUN: go to STOPPING.
  - STOPPING + `FRAME_TICK`: enables go to 0, then IDLE.
  - IDLE: ignored.
  - `START` and `STOP` in the same cycle: `STOP` wins.
- Applying an entry means loading `TX_SLOT`, `RX_SLOT`, `TXSLOT_EN` and `RXSLOT_EN` in a single cycle. The TPU never sees a partial update.
- Table:
  - Writable in every state.
  - Contents are not cleared by `RSTSCH`.
  - If a write and an apply hit the same entry in the same cycle, the apply uses the old contents.
  - `WR_ADDR` ≥ DEPTH is impossible by width; writes beyond latched `LAST_IDX` are legal but unused.
- `FRAME_TICK` asserted on consecutive cycles counts as one frame per high cycle; no filtering.

## Timing
- Reset values: `TX_SLOT`=0, `RX_SLOT`=0, `TXSLOT_EN`=0, `RXSLOT_EN`=0, `CUR_IDX`=0, `BUSY`=0, `WRAP_IRQ`=0, `CONFLICT`=0, state IDLE, repeat counter 0.
- `RSTSCH` mid-schedule returns to reset values on the next edge. Table contents are retained.
- Apply latency: outputs, `CUR_IDX`, `WRAP_IRQ` and `CONFLICT` change on the edge that samples `FRAME_TICK` high, so they are visible one cycle after the tick.
- `BUSY` rises on the edge sampling `START` and falls on the edge entering IDLE.
- A table write is visible to an apply from the cycle after `WR_EN`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `TPU_SCHED_CONFLICT_CHK_EN`.
- Defined:
  - On apply, if tx_en=1, rx_en=1 and tx_slot==rx_slot, `RXSLOT_EN` is forced to 0.
  - TX is kept.
  - `CONFLICT` pulses for one cycle alongside the apply.
- Undefined:
  - Entries are applied verbatim.
  - `CONFLICT` is tied to 0.

## Test plan
- Reset: hold `RSTSCH` for 2 cycles and check all outputs at reset values. Then program entry0 = {rpt 0, en 1/1, tx 60, rx 120}, `START` and one `FRAME_TICK` → `TX_SLOT`=60, `RX_SLOT`=120 and both enables 1 one cycle after the tick, with `BUSY`=1.
- Repeat and wrap: program entry0 {rpt 2, tx 10, rx 20} and entry1 {rpt 0, tx 30, rx 40}, with `LAST_IDX`=1. Apply 7 ticks → `CUR_IDX` sequence 0,0,0,1,0,0,0. `WRAP_IRQ` pulses exactly once, at tick 5.
- Stop: `STOP` while in RUN → outputs unchanged until the next tick, then enables 0 and `BUSY` 0. `STOP` while in ARM → `BUSY` 0 next cycle with no tick needed.
- Collision: in the same cycle as a tick that advances to entry1, write entry1 = {tx 5, rx 5} → the apply uses the old entry1 (30/40), and the new value appears on the next wrap.
- Conflict (macro defined): entry {en 1/1, tx 60, rx 60} → `RXSLOT_EN`=0, `TXSLOT_EN`=1, one-cycle `CONFLICT`. With the macro undefined, both enables are 1 and `CONFLICT`=0.
- Reset mid-run: assert `RSTSCH` in RUN with `CUR_IDX`=1 → all outputs at reset values next cycle. `START` again → resumes from entry 0 using the retained table.
